// File: rtl/ftq_train_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ftq_train_scheduler_if
// Purpose  : Commit, FTQ read-port and BPU training signals of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface ftq_train_scheduler_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int FTQ_ID_W     = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int CTR_W        = 2
);
  localparam int c_pkt_w = 3*ADDR_WIDTH + CTR_W + 6;

  logic [COMMIT_WIDTH-1:0]          commit_valid_i;
  logic [COMMIT_WIDTH-1:0]          commit_is_branch_i;
  logic [COMMIT_WIDTH-1:0]          commit_is_cond_i;
  logic [COMMIT_WIDTH-1:0]          commit_taken_i;
  logic [COMMIT_WIDTH-1:0]          commit_pred_taken_i;
  logic [COMMIT_WIDTH*FTQ_ID_W-1:0] commit_ftq_id_i;
  logic [FTQ_ID_W-1:0]              ftq_rd_id_o;
  logic [ADDR_WIDTH-1:0]            ftq_rd_start_pc_i;
  logic                             ftq_rd_cross_i;
  logic [CTR_W-1:0]                 ftq_rd_ctr_i;
  logic [ADDR_WIDTH-1:0]            ftq_rd_target_i;
  logic [ADDR_WIDTH-1:0]            ftq_rd_fall_i;
  logic                             train_valid_o;
  logic                             train_ready_i;
  logic [c_pkt_w-1:0]               train_pkt_o;
  logic [15:0]                      drop_cnt_o;

  modport slave (
    input  commit_valid_i, commit_is_branch_i, commit_is_cond_i, commit_taken_i,
    input  commit_pred_taken_i, commit_ftq_id_i,
    input  ftq_rd_start_pc_i, ftq_rd_cross_i, ftq_rd_ctr_i, ftq_rd_target_i, ftq_rd_fall_i,
    input  train_ready_i,
    output ftq_rd_id_o, train_valid_o, train_pkt_o, drop_cnt_o
  );

  modport master (
    output commit_valid_i, commit_is_branch_i, commit_is_cond_i, commit_taken_i,
    output commit_pred_taken_i, commit_ftq_id_i,
    output ftq_rd_start_pc_i, ftq_rd_cross_i, ftq_rd_ctr_i, ftq_rd_target_i, ftq_rd_fall_i,
    output train_ready_i,
    input  ftq_rd_id_o, train_valid_o, train_pkt_o, drop_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/ftq_train_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ftq_train_scheduler
// Purpose  : Buffers committed branches and feeds them one per cycle to BPU training.
// Revision : 1.0 - initial release
// ============================================================================
module ftq_train_scheduler #(
  parameter int COMMIT_WIDTH = 2,
  parameter int FTQ_ID_W     = 3,
  parameter int DEPTH        = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int CTR_W        = 2
) (
  input wire                   clk,
  input wire                   rst_n,
  ftq_train_scheduler_if.slave bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_ent_w = FTQ_ID_W + 3;
  localparam int c_pkt_w = 3*ADDR_WIDTH + CTR_W + 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_ent_w-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [15:0]          r_drop_cnt;
  logic [c_pkt_w-1:0]   r_pkt;

  logic [COMMIT_WIDTH-1:0] w_elig;
  logic [COMMIT_WIDTH-1:0] w_wr_en;
  logic [c_ptr_w-1:0]      w_wr_addr [COMMIT_WIDTH];
  logic [c_ent_w-1:0]      w_slot_ent [COMMIT_WIDTH];
  logic [c_cnt_w-1:0]      w_free;
  logic [c_cnt_w-1:0]      w_push_cnt;
  logic [c_cnt_w-1:0]      w_drop_n;
  logic [16:0]             w_drop_sum;
  logic [c_ent_w-1:0]      w_head;
  logic                    w_empty;
  logic                    w_pop;

  assign w_elig  = bus.commit_valid_i & bus.commit_is_branch_i;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_empty = (r_count == '0);

  generate
    for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_slot
      assign w_slot_ent[i] = {bus.commit_ftq_id_i[i*FTQ_ID_W +: FTQ_ID_W],
                              bus.commit_is_cond_i[i],
                              bus.commit_taken_i[i],
                              bus.commit_pred_taken_i[i]};
    end
  endgenerate

  // Older slots claim free entries first, so overflow always drops the youngest.
  always_comb begin
    w_free     = c_cnt_w'(DEPTH) - r_count;
    w_push_cnt = '0;
    w_drop_n   = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_wr_en[i]   = 1'b0;
      w_wr_addr[i] = r_wr_ptr + w_push_cnt[c_ptr_w-1:0];
      if (w_elig[i]) begin
        if (w_push_cnt < w_free) begin
          w_wr_en[i] = 1'b1;
          w_push_cnt = w_push_cnt + c_cnt_w'(1);
        end else begin
          w_drop_n = w_drop_n + c_cnt_w'(1);
        end
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_mem[j] <= '0;
      end
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (w_wr_en[i]) begin
          r_mem[w_wr_addr[i]] <= w_slot_ent[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + w_push_cnt[c_ptr_w-1:0];
      r_rd_ptr   <= r_rd_ptr + c_ptr_w'(w_pop);
      r_count    <= r_count + w_push_cnt - c_cnt_w'(w_pop);
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  // Pops only look at the registered count, so a fresh push is never bypassed.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = VALID;
        end
      end
      VALID: begin
        if (bus.train_ready_i) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt <= '0;
    end else if (w_pop) begin
      r_pkt <= {bus.ftq_rd_start_pc_i, bus.ftq_rd_cross_i, bus.ftq_rd_ctr_i,
                bus.ftq_rd_target_i, bus.ftq_rd_fall_i,
                1'b1, w_head[2], w_head[1], w_head[0], w_head[1] ^ w_head[0]};
    end
  end

  assign bus.ftq_rd_id_o   = w_empty ? '0 : w_head[c_ent_w-1 -: FTQ_ID_W];
  assign bus.train_valid_o = (r_state == VALID);
  assign bus.train_pkt_o   = r_pkt;
  assign bus.drop_cnt_o    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ftq_train_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ftq_train_scheduler
// Purpose  : Directed self-checking bench for ftq_train_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ftq_train_scheduler;
  localparam int c_pkt_w = 3*32 + 2 + 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ftq_train_scheduler_if #(.COMMIT_WIDTH(2), .FTQ_ID_W(3), .ADDR_WIDTH(32), .CTR_W(2)) bus ();

  ftq_train_scheduler #(
    .COMMIT_WIDTH(2), .FTQ_ID_W(3), .DEPTH(4), .ADDR_WIDTH(32), .CTR_W(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // FTQ model: entry contents are a fixed function of the index.
  function automatic logic [31:0] m_spc(input logic [2:0] id);
    return 32'h8000_0000 | {23'd0, id, 6'd0};
  endfunction
  function automatic logic [31:0] m_tgt(input logic [2:0] id);
    return 32'hA000_0000 + {29'd0, id};
  endfunction

  assign bus.ftq_rd_start_pc_i = m_spc(bus.ftq_rd_id_o);
  assign bus.ftq_rd_cross_i    = bus.ftq_rd_id_o[0];
  assign bus.ftq_rd_ctr_i      = bus.ftq_rd_id_o[2:1];
  assign bus.ftq_rd_target_i   = m_tgt(bus.ftq_rd_id_o);
  assign bus.ftq_rd_fall_i     = m_spc(bus.ftq_rd_id_o) + 32'd32;

  function automatic logic [c_pkt_w-1:0] exp_pkt(input logic [2:0] id, input logic c,
                                                 input logic t, input logic p);
    return {m_spc(id), id[0], id[2:1], m_tgt(id), m_spc(id) + 32'd32, 1'b1, c, t, p, t ^ p};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_commit();
    bus.commit_valid_i      = '0;
    bus.commit_is_branch_i  = '0;
    bus.commit_is_cond_i    = '0;
    bus.commit_taken_i      = '0;
    bus.commit_pred_taken_i = '0;
    bus.commit_ftq_id_i     = '0;
  endtask

  // Both slots are branches; slot0 cond/taken/pred=1/1/1, slot1 0/0/1.
  task automatic drive2(input logic [2:0] id0, input logic [2:0] id1);
    bus.commit_valid_i      = 2'b11;
    bus.commit_is_branch_i  = 2'b11;
    bus.commit_is_cond_i    = 2'b01;
    bus.commit_taken_i      = 2'b01;
    bus.commit_pred_taken_i = 2'b11;
    bus.commit_ftq_id_i     = {id1, id0};
  endtask

  initial begin
    logic [2:0] ids [5];
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.train_ready_i = 1'b0;
    clear_commit();

    // Reset state
    tick();
    check("rst_valid", 128'(bus.train_valid_o), 128'(1'b0));
    check("rst_pkt",   128'(bus.train_pkt_o),   128'(0));
    check("rst_drop",  128'(bus.drop_cnt_o),    128'(0));
    check("rst_rdid",  128'(bus.ftq_rd_id_o),   128'(0));
    rst_n = 1'b1;
    tick();

    // Single branch, slot0, id 5, mispredicted, ready held high
    bus.train_ready_i       = 1'b1;
    bus.commit_valid_i      = 2'b01;
    bus.commit_is_branch_i  = 2'b01;
    bus.commit_is_cond_i    = 2'b01;
    bus.commit_taken_i      = 2'b01;
    bus.commit_pred_taken_i = 2'b00;
    bus.commit_ftq_id_i     = {3'd0, 3'd5};
    tick();
    clear_commit();
    check("single_rdid_n1",  128'(bus.ftq_rd_id_o),   128'(3'd5));
    check("single_valid_n1", 128'(bus.train_valid_o), 128'(1'b0));
    tick();
    check("single_valid_n2", 128'(bus.train_valid_o), 128'(1'b1));
    check("single_pkt_n2",   128'(bus.train_pkt_o),   128'(exp_pkt(3'd5, 1'b1, 1'b1, 1'b0)));
    check("single_mispred",  128'(bus.train_pkt_o[0]), 128'(1'b1));
    tick();
    check("single_valid_n3", 128'(bus.train_valid_o), 128'(1'b0));
    check("single_rdid_n3",  128'(bus.ftq_rd_id_o),   128'(0));

    // slot0 non-branch, slot1 branch id 7
    bus.train_ready_i       = 1'b0;
    bus.commit_valid_i      = 2'b11;
    bus.commit_is_branch_i  = 2'b10;
    bus.commit_ftq_id_i     = {3'd7, 3'd1};
    tick();
    clear_commit();
    check("nb_rdid", 128'(bus.ftq_rd_id_o), 128'(3'd7));
    tick();
    check("nb_valid", 128'(bus.train_valid_o), 128'(1'b1));
    check("nb_pkt",   128'(bus.train_pkt_o),   128'(exp_pkt(3'd7, 1'b0, 1'b0, 1'b0)));
    check("nb_rdid_empty", 128'(bus.ftq_rd_id_o), 128'(0));
    bus.train_ready_i = 1'b1;
    tick();
    bus.train_ready_i = 1'b0;
    check("nb_only_one", 128'(bus.train_valid_o), 128'(1'b0));
    check("nb_drop",     128'(bus.drop_cnt_o),    128'(0));

    // Overflow with ready low: ids 2,3,4,5,6 kept; 1, 0, 7 dropped
    drive2(3'd2, 3'd3); tick();
    drive2(3'd4, 3'd5); tick();
    drive2(3'd6, 3'd1); tick();
    drive2(3'd0, 3'd7); tick();
    clear_commit();
    check("ovf_drop",  128'(bus.drop_cnt_o),  128'(16'd3));
    check("ovf_valid", 128'(bus.train_valid_o), 128'(1'b1));
    check("ovf_rdid",  128'(bus.ftq_rd_id_o),   128'(3'd3));

    // Drain with ready toggling: each packet must hold while ready is low
    ids = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain_valid_%0d", k), 128'(bus.train_valid_o), 128'(1'b1));
      check($sformatf("drain_pkt_%0d", k), 128'(bus.train_pkt_o),
            128'(exp_pkt(ids[k], ~ids[k][0], ~ids[k][0], 1'b1)));
      tick();
      check($sformatf("drain_hold_%0d", k), 128'(bus.train_pkt_o),
            128'(exp_pkt(ids[k], ~ids[k][0], ~ids[k][0], 1'b1)));
      bus.train_ready_i = 1'b1;
      tick();
      bus.train_ready_i = 1'b0;
    end
    check("drain_done", 128'(bus.train_valid_o), 128'(1'b0));

    // Reset while VALID with three entries queued
    drive2(3'd1, 3'd2); tick();
    drive2(3'd3, 3'd4); tick();
    clear_commit();
    check("midrst_pre_valid", 128'(bus.train_valid_o), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(bus.train_valid_o), 128'(1'b0));
    check("midrst_drop",  128'(bus.drop_cnt_o),    128'(0));
    check("midrst_rdid",  128'(bus.ftq_rd_id_o),   128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("postrst_valid", 128'(bus.train_valid_o), 128'(1'b0));
    check("postrst_rdid",  128'(bus.ftq_rd_id_o),   128'(0));

    // Drop counter: 15 after 10 overflowing cycles, then saturation
    for (int k = 0; k < 10; k++) begin
      drive2(3'd1, 3'd2);
      tick();
    end
    check("drop_15", 128'(bus.drop_cnt_o), 128'(16'd15));
    for (int k = 0; k < 35000; k++) begin
      tick();
    end
    clear_commit();
    check("drop_sat",       128'(bus.drop_cnt_o),    128'(16'hFFFF));
    check("drop_sat_valid", 128'(bus.train_valid_o), 128'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
